icache_miss_fsm: RTL and testbench

Parametrised control FSM for the N-way set-associative instruction cache. It sits between the fetch-stage request port and the AXI-style read channel to memory. It handles hit lookup, address-phase and data-phase handshakes for a configurable-length line burst, per-beat fill-buffer writes, way refill, and LRU updates. It adds a fetch-cancel (redirect) capability so a branch flush can abandon an in-flight miss without corrupting the cache.

---
 rtl/icache_miss_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_icache_miss_fsm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_miss_fsm.sv
// icache_miss_fsm: control FSM for an N-way set-associative instruction cache.
// It takes fetch requests, resolves hits in LOOKUP, and on a miss it runs one
// AXI-style line burst. Each beat goes into the fill buffer, and the line is then
// refilled into the LRU victim way. A fetch redirect (cancel) abandons the
// response, but the burst still completes and the line is still refilled.
module icache_miss_fsm #(
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int OFFS_W     = $clog2(LINE_WORDS) + 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rvalid,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          cancel,
  input  logic [WAYS-1:0]               hit,
  input  logic [$clog2(WAYS)-1:0]       victim_way,
  input  logic                          i_arready,
  input  logic                          i_rvalid,
  input  logic                          i_rlast,
  output logic                          rready,
  output logic                          i_arvalid,
  output logic [ADDR_W-1:0]             i_araddr,
  output logic [7:0]                    i_arlen,
  output logic                          i_rready,
  output logic                          rbuf_we,
  output logic                          fbuf_we,
  output logic [$clog2(LINE_WORDS)-1:0] fbuf_idx,
  output logic                          fbuf_clear,
  output logic                          data_from_mem_sel,
  output logic [WAYS-1:0]               mem_we,
  output logic [WAYS-1:0]               TagV_we,
  output logic                          LRU_update,
  output logic                          miss_LRU_update,
  output logic [$clog2(WAYS)-1:0]       miss_lru_way,
  output logic                          resp_valid
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MISS_A = 3'd2,
    MISS_D = 3'd3,
    REFILL = 3'd4,
    DRAIN  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;
  state_t eff_state;

  logic [ADDR_W-1:OFFS_W] addr_r;
  logic [IDX_W-1:0]       counter;
  logic [WAY_W-1:0]       way_r;
  logic                   cancel_pend;
  logic                   err;
  logic                   overflow;

  logic                   way_load;
  logic                   cnt_clear;
  logic                   beat;
  logic                   err_set;
  logic [WAYS-1:0]        way_onehot;

  // The byte-offset bits of the fetch address never reach memory, because
  // bursts are always line-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[OFFS_W-1:0];

  assign i_arlen    = 8'(LINE_WORDS - 1);
  assign way_onehot = WAYS'(1) << way_r;

  // While rstn is low the outputs must look like IDLE, even before the reset edge.
  assign eff_state = rstn ? state : IDLE;

  // State, request buffer, beat counter and sticky flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      addr_r      <= '0;
      counter     <= '0;
      way_r       <= '0;
      cancel_pend <= 1'b0;
      err         <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_next;
      if (rbuf_we) begin
        addr_r <= addr[ADDR_W-1:OFFS_W];
      end
      if (way_load) begin
        way_r <= victim_way;
      end
      if (cnt_clear) begin
        counter  <= '0;
        overflow <= 1'b0;
      end else if (beat) begin
        counter <= counter + IDX_W'(1);
        if (counter == LAST_BEAT) begin
          overflow <= 1'b1;
        end
      end
      if (state_next == IDLE) begin
        cancel_pend <= 1'b0;
      end else if (cancel && (state == MISS_A || state == MISS_D)) begin
        cancel_pend <= 1'b1;
      end
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Next-state logic and all handshake and write-enable outputs.
  always_comb begin
    state_next        = eff_state;
    rready            = 1'b0;
    rbuf_we           = 1'b0;
    fbuf_clear        = 1'b0;
    data_from_mem_sel = 1'b1;
    i_arvalid         = 1'b0;
    i_araddr          = '0;
    i_rready          = 1'b0;
    fbuf_we           = 1'b0;
    fbuf_idx          = '0;
    mem_we            = '0;
    TagV_we           = '0;
    LRU_update        = 1'b0;
    miss_LRU_update   = 1'b0;
    miss_lru_way      = '0;
    resp_valid        = 1'b0;
    way_load          = 1'b0;
    cnt_clear         = 1'b0;
    beat              = 1'b0;
    err_set           = 1'b0;

    case (eff_state)
      IDLE: begin
        rready     = 1'b1;
        rbuf_we    = 1'b1;
        fbuf_clear = 1'b1;
        if (rvalid) begin
          state_next = LOOKUP;
        end
      end

      LOOKUP: begin
        data_from_mem_sel = 1'b0;
        if (cancel) begin
          state_next = IDLE;
        end else if (|hit) begin
          LRU_update = 1'b1;
          if (rvalid) begin
            rready  = 1'b1;
            rbuf_we = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          way_load   = 1'b1;
          state_next = MISS_A;
        end
      end

      MISS_A: begin
        i_arvalid = 1'b1;
        i_araddr  = {addr_r, {OFFS_W{1'b0}}};
        if (i_arready) begin
          cnt_clear  = 1'b1;
          state_next = MISS_D;
        end
      end

      MISS_D: begin
        i_rready = 1'b1;
        if (i_rvalid) begin
          beat     = 1'b1;
          fbuf_we  = !overflow;
          fbuf_idx = counter;
          if (i_rlast) begin
            state_next = REFILL;
            if (counter != LAST_BEAT || overflow) begin
              err_set = 1'b1;
            end
          end
        end
      end

      REFILL: begin
        mem_we          = way_onehot;
        TagV_we         = err ? '0 : way_onehot;
        miss_LRU_update = 1'b1;
        miss_lru_way    = way_r;
        resp_valid      = !(cancel_pend || cancel || err);
        state_next      = IDLE;
      end

      default: begin
        rready     = 1'b1;
        rbuf_we    = 1'b1;
        fbuf_clear = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_miss_fsm.sv
// tb_icache_miss_fsm: directed checks of the icache miss FSM. The first part is
// a cycle table of hit, cancel and miss-entry vectors. The rest are hand-written
// miss, cancel, early-rlast and mid-burst reset sequences.
module tb_icache_miss_fsm;

  logic        clk;
  logic        rstn;
  logic        rvalid;
  logic [31:0] addr;
  logic        cancel;
  logic [3:0]  hit;
  logic [1:0]  victim_way;
  logic        i_arready;
  logic        i_rvalid;
  logic        i_rlast;
  logic        rready;
  logic        i_arvalid;
  logic [31:0] i_araddr;
  logic [7:0]  i_arlen;
  logic        i_rready;
  logic        rbuf_we;
  logic        fbuf_we;
  logic [2:0]  fbuf_idx;
  logic        fbuf_clear;
  logic        data_from_mem_sel;
  logic [3:0]  mem_we;
  logic [3:0]  TagV_we;
  logic        LRU_update;
  logic        miss_LRU_update;
  logic [1:0]  miss_lru_way;
  logic        resp_valid;

  int total;
  int bad;

  icache_miss_fsm #(
    .WAYS(4),
    .LINE_WORDS(8),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rvalid(rvalid),
    .addr(addr),
    .cancel(cancel),
    .hit(hit),
    .victim_way(victim_way),
    .i_arready(i_arready),
    .i_rvalid(i_rvalid),
    .i_rlast(i_rlast),
    .rready(rready),
    .i_arvalid(i_arvalid),
    .i_araddr(i_araddr),
    .i_arlen(i_arlen),
    .i_rready(i_rready),
    .rbuf_we(rbuf_we),
    .fbuf_we(fbuf_we),
    .fbuf_idx(fbuf_idx),
    .fbuf_clear(fbuf_clear),
    .data_from_mem_sel(data_from_mem_sel),
    .mem_we(mem_we),
    .TagV_we(TagV_we),
    .LRU_update(LRU_update),
    .miss_LRU_update(miss_LRU_update),
    .miss_lru_way(miss_lru_way),
    .resp_valid(resp_valid)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected output flags are packed as
  // {rready, rbuf_we, fbuf_clear, data_from_mem_sel,
  //  LRU_update, i_arvalid, i_rready, resp_valid}.
  typedef struct {
    logic        rstn;
    logic        rvalid;
    logic [31:0] addr;
    logic        cancel;
    logic [3:0]  hit;
    logic [1:0]  victim;
    logic        arready;
    logic        mrvalid;
    logic        mlast;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic r, logic v, logic [31:0] a, logic c, logic [3:0] h,
                              logic [1:0] vw, logic ar, logic mv, logic ml, logic [7:0] e);
    vec_t t;
    t.rstn = r; t.rvalid = v; t.addr = a; t.cancel = c; t.hit = h;
    t.victim = vw; t.arready = ar; t.mrvalid = mv; t.mlast = ml; t.exp = e;
    return t;
  endfunction

  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] a,
                               input logic c, input logic [3:0] h, input logic [1:0] vw,
                               input logic ar, input logic mv, input logic ml);
    rstn = r; rvalid = v; addr = a; cancel = c; hit = h;
    victim_way = vw; i_arready = ar; i_rvalid = mv; i_rlast = ml;
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0, 1'b0);
    nextCycle();
  endtask

  // Test sequence: table first, then the multi-cycle corner cases.
  initial begin
    int arv_cnt;
    int b;
    logic mv;
    logic [31:0] a_miss;
    logic [31:0] a_can;
    total = 0;
    bad   = 0;

    vecs[0]  = mk(0, 0, 32'h0000_0000, 0, 4'b0000, 2'd0, 0, 0, 0, 8'b1111_0000);
    vecs[1]  = mk(0, 1, 32'h0000_0100, 0, 4'b0000, 2'd0, 0, 0, 0, 8'b1111_0000);
    vecs[2]  = mk(1, 1, 32'h0000_0100, 0, 4'b0000, 2'd0, 0, 0, 0, 8'b1111_0000);
    vecs[3]  = mk(1, 1, 32'h0000_0104, 0, 4'b0100, 2'd0, 0, 0, 0, 8'b1100_1000);
    vecs[4]  = mk(1, 1, 32'h0000_0108, 0, 4'b0100, 2'd0, 0, 0, 0, 8'b1100_1000);
    vecs[5]  = mk(1, 1, 32'h0000_010C, 0, 4'b0100, 2'd0, 0, 0, 0, 8'b1100_1000);
    vecs[6]  = mk(1, 1, 32'h0000_0110, 0, 4'b0100, 2'd0, 0, 0, 0, 8'b1100_1000);
    vecs[7]  = mk(1, 0, 32'h0000_0110, 0, 4'b0100, 2'd0, 0, 0, 0, 8'b0000_1000);
    vecs[8]  = mk(1, 0, 32'h0000_0000, 0, 4'b0000, 2'd0, 0, 0, 0, 8'b1111_0000);
    vecs[9]  = mk(1, 1, 32'h0000_0200, 0, 4'b0000, 2'd0, 0, 0, 0, 8'b1111_0000);
    vecs[10] = mk(1, 1, 32'h0000_0200, 1, 4'b0100, 2'd0, 0, 0, 0, 8'b0000_0000);
    vecs[11] = mk(1, 1, 32'h0000_0300, 0, 4'b0000, 2'd0, 0, 0, 0, 8'b1111_0000);
    vecs[12] = mk(1, 1, 32'h0000_0300, 0, 4'b0000, 2'd1, 0, 0, 0, 8'b0000_0000);
    vecs[13] = mk(1, 1, 32'h0000_0300, 0, 4'b0000, 2'd1, 0, 0, 0, 8'b0001_0100);
    vecs[14] = mk(1, 1, 32'h0000_0300, 0, 4'b0000, 2'd1, 1, 0, 0, 8'b0001_0100);
    vecs[15] = mk(0, 1, 32'h0000_0300, 0, 4'b0000, 2'd1, 0, 1, 0, 8'b1111_0000);
    vecs[16] = mk(1, 0, 32'h0000_0000, 0, 4'b0000, 2'd0, 0, 0, 0, 8'b1111_0000);

    #1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].rvalid, vecs[i].addr, vecs[i].cancel, vecs[i].hit,
                    vecs[i].victim, vecs[i].arready, vecs[i].mrvalid, vecs[i].mlast);
      checkOutput($sformatf("vec%0d_flags", i),
                  {24'h0, rready, rbuf_we, fbuf_clear, data_from_mem_sel,
                   LRU_update, i_arvalid, i_rready, resp_valid},
                  {24'h0, vecs[i].exp});
      nextCycle();
    end
    checkOutput("arlen_const", 32'(i_arlen), 32'd7);

    // Full miss: victim way 2, address accepted after three stall cycles.
    resetDut();
    a_miss = 32'h1234_56A4;
    applyStimulus(1, 1, a_miss, 0, 4'h0, 2'd2, 0, 0, 0);
    checkOutput("miss_idle_rready", 32'(rready), 32'd1);
    nextCycle();
    applyStimulus(1, 1, a_miss, 0, 4'h0, 2'd2, 0, 0, 0);
    checkOutput("miss_lookup_rready", 32'(rready), 32'd0);
    nextCycle();
    arv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, a_miss, 0, 4'h0, 2'd0, (i == 3), 0, 0);
      if (i_arvalid) arv_cnt++;
      if (i == 0) checkOutput("miss_araddr", i_araddr, 32'h1234_56A0);
      nextCycle();
    end
    checkOutput("miss_arvalid_cycles", 32'(arv_cnt), 32'd4);
    b = 0;
    for (int c = 0; c < 9; c++) begin
      mv = (c != 4);
      applyStimulus(1, 1, a_miss, 0, 4'h0, 2'd0, 0, mv, (mv && b == 7));
      checkOutput($sformatf("miss_rready_c%0d", c), 32'(i_rready), 32'd1);
      checkOutput($sformatf("miss_fbuf_we_c%0d", c), 32'(fbuf_we), 32'(mv));
      if (mv) begin
        checkOutput($sformatf("miss_fbuf_idx_b%0d", b), 32'(fbuf_idx), 32'(b));
        b++;
      end
      nextCycle();
    end
    applyStimulus(1, 1, a_miss, 0, 4'h0, 2'd0, 0, 0, 0);
    checkOutput("miss_mem_we", 32'(mem_we), 32'h4);
    checkOutput("miss_tagv_we", 32'(TagV_we), 32'h4);
    checkOutput("miss_lru_upd", 32'(miss_LRU_update), 32'd1);
    checkOutput("miss_lru_way", 32'(miss_lru_way), 32'd2);
    checkOutput("miss_resp_valid", 32'(resp_valid), 32'd1);
    nextCycle();
    applyStimulus(1, 0, 32'h0, 0, 4'h0, 2'd0, 0, 0, 0);
    checkOutput("miss_back_idle", 32'(rready), 32'd1);
    checkOutput("miss_resp_gone", 32'(resp_valid), 32'd0);
    nextCycle();

    // Cancel on beat index 3: the line is still refilled, but no response is given.
    a_can = 32'h0000_4440;
    applyStimulus(1, 1, a_can, 0, 4'h0, 2'd1, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, a_can, 0, 4'h0, 2'd1, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, a_can, 0, 4'h0, 2'd0, 1, 0, 0);
    checkOutput("can_arvalid", 32'(i_arvalid), 32'd1);
    checkOutput("can_araddr", i_araddr, 32'h0000_4440);
    nextCycle();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, (k < 3), a_can, (k == 3), 4'h0, 2'd0, 0, 1, (k == 7));
      checkOutput($sformatf("can_fbuf_we_b%0d", k), 32'(fbuf_we), 32'd1);
      nextCycle();
    end
    applyStimulus(1, 0, 32'h0, 0, 4'h0, 2'd0, 0, 0, 0);
    checkOutput("can_mem_we", 32'(mem_we), 32'h2);
    checkOutput("can_tagv_we", 32'(TagV_we), 32'h2);
    checkOutput("can_resp_valid", 32'(resp_valid), 32'd0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_5000, 0, 4'h0, 2'd0, 0, 0, 0);
    checkOutput("can_idle_rready", 32'(rready), 32'd1);
    nextCycle();
    applyStimulus(1, 0, 32'h0, 0, 4'b0001, 2'd0, 0, 0, 0);
    checkOutput("can_next_hit", 32'(LRU_update), 32'd1);
    nextCycle();

    // Early rlast on the second beat: refill without validating the tag.
    applyStimulus(1, 1, 32'h0000_7780, 0, 4'h0, 2'd3, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_7780, 0, 4'h0, 2'd3, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_7780, 0, 4'h0, 2'd0, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_7780, 0, 4'h0, 2'd0, 0, 1, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_7780, 0, 4'h0, 2'd0, 0, 1, 1);
    checkOutput("early_fbuf_idx", 32'(fbuf_idx), 32'd1);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_7780, 0, 4'h0, 2'd0, 0, 0, 0);
    checkOutput("early_tagv_we", 32'(TagV_we), 32'h0);
    checkOutput("early_mem_we", 32'(mem_we), 32'h8);
    checkOutput("early_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("early_err", 32'(dut.err), 32'd1);
    nextCycle();

    // Reset asserted in the middle of a burst.
    applyStimulus(1, 1, 32'h0000_9900, 0, 4'h0, 2'd0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_9900, 0, 4'h0, 2'd0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_9900, 0, 4'h0, 2'd0, 1, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_9900, 0, 4'h0, 2'd0, 0, 1, 0);
    checkOutput("rst_beat0_idx", 32'(fbuf_idx), 32'd0);
    nextCycle();
    applyStimulus(1, 1, 32'h0000_9900, 0, 4'h0, 2'd0, 0, 1, 0);
    nextCycle();
    applyStimulus(0, 1, 32'h0000_9900, 0, 4'h0, 2'd0, 0, 1, 0);
    checkOutput("rst_mid_rready_mem", 32'(i_rready), 32'd0);
    checkOutput("rst_mid_fbuf_we", 32'(fbuf_we), 32'd0);
    checkOutput("rst_mid_rready", 32'(rready), 32'd1);
    nextCycle();
    applyStimulus(1, 0, 32'h0, 0, 4'h0, 2'd0, 0, 0, 0);
    checkOutput("rst_state", 32'(dut.state), 32'd0);
    checkOutput("rst_counter", 32'(dut.counter), 32'd0);
    checkOutput("rst_err", 32'(dut.err), 32'd0);
    checkOutput("rst_i_rready", 32'(i_rready), 32'd0);
    checkOutput("rst_araddr", i_araddr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
